// File: rtl/if_fetch_queue_if.sv
// Bundle between the fetch queue and its neighbours: PC (pc/flush/stall_out),
// instruction memory (req/gnt + rvalid) and decode (instr_valid/id_ready).
interface if_fetch_queue_if;
  // Handshakes: a request transfers when imem_req & imem_gnt; a response is
  // imem_rvalid for one cycle, in request order; decode pops when
  // instr_valid & id_ready. Valids never depend on their own ready.
  logic [31:0] pc;
  logic        flush;
  logic        stall_out;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        id_ready;

  modport master (
    output pc, flush, imem_gnt, imem_rvalid, imem_rdata, id_ready,
    input  stall_out, imem_req, imem_addr, instr_valid, instr, instr_pc
  );

  modport slave (
    input  pc, flush, imem_gnt, imem_rvalid, imem_rdata, id_ready,
    output stall_out, imem_req, imem_addr, instr_valid, instr, instr_pc
  );
endinterface

// File: rtl/if_fetch_queue.sv
// Fetch queue: issues PC addresses to instruction memory, buffers returned
// instructions in order for decode, and drops responses orphaned by a flush.
module if_fetch_queue #(
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  if_fetch_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_C = DEPTH[CW:0];

  typedef logic [AW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  logic [31:0] slot_pc    [DEPTH];
  logic [31:0] slot_instr [DEPTH];

  ptr_t wr_req, wr_dat, rd;
  cnt_t reserved, filled, discard;

  logic        can_issue, grant, fill, drop, pop, outstanding;
  logic [CW:0] occupancy;
  logic [CW:0] flush_sum;
  logic [CW:0] flush_discard;
  logic        unused_pc_low;

  assign unused_pc_low = &{1'b0, bus.pc[1:0]};

  always_comb begin
    occupancy       = {1'b0, reserved} + {1'b0, discard};
    can_issue       = occupancy < DEPTH_C;
    bus.imem_req    = can_issue & ~bus.flush & rst_n;
    bus.imem_addr   = {bus.pc[31:2], 2'b00};
    grant           = bus.imem_req & bus.imem_gnt;
    bus.stall_out   = rst_n & ~bus.flush & ~grant;
    outstanding     = reserved != filled;
    drop            = bus.imem_rvalid & (discard != '0);
    fill            = bus.imem_rvalid & (discard == '0) & outstanding & ~bus.flush;
    bus.instr_valid = (filled != '0) & ~bus.flush & rst_n;
    pop             = bus.instr_valid & bus.id_ready;
    bus.instr       = slot_instr[rd];
    bus.instr_pc    = slot_pc[rd];
    // Everything still in flight at a flush becomes a response to discard,
    // minus the one arriving in the flush cycle itself.
    flush_sum       = {1'b0, discard} + {1'b0, cnt_t'(reserved - filled)};
    flush_discard   = flush_sum;
    if (bus.imem_rvalid && flush_sum != '0) flush_discard = flush_sum - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_req   <= '0;
      wr_dat   <= '0;
      rd       <= '0;
      reserved <= '0;
      filled   <= '0;
      discard  <= '0;
    end else if (bus.flush) begin
      wr_req   <= '0;
      wr_dat   <= '0;
      rd       <= '0;
      reserved <= '0;
      filled   <= '0;
      discard  <= flush_discard[CW-1:0];
    end else begin
      wr_req   <= wr_req + ptr_t'(grant);
      wr_dat   <= wr_dat + ptr_t'(fill);
      rd       <= rd + ptr_t'(pop);
      reserved <= reserved + cnt_t'(grant) - cnt_t'(pop);
      filled   <= filled + cnt_t'(fill) - cnt_t'(pop);
      discard  <= discard - cnt_t'(drop);
    end
  end

  // Slot contents need no reset: counters gate every read.
  always_ff @(posedge clk) begin
    if (grant) slot_pc[wr_req]    <= bus.imem_addr;
    if (fill)  slot_instr[wr_dat] <= bus.imem_rdata;
  end
endmodule

// File: tb/tb_if_fetch_queue.sv
// Randomized bench for if_fetch_queue: PC, memory and decode stubs around the
// DUT, checked every cycle against a queue-level reference model.
module tb_if_fetch_queue;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  if_fetch_queue_if bus();

  if_fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: in-flight requests in order (with stale flag) and the
  // decode-visible queue of {pc, instr}.
  logic [31:0] inf_addr[$];
  bit          inf_stale[$];
  logic [31:0] exp_pc_q[$];
  logic [31:0] exp_q[$];
  // Memory stub: addresses granted but not yet answered.
  logic [31:0] mem_q[$];

  logic [31:0] pc_reg;
  int p_gnt, p_rv, p_rdy, p_fl;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_1234;
  endfunction

  task automatic set_knobs(input int g, input int r, input int d, input int f);
    p_gnt = g; p_rv = r; p_rdy = d; p_fl = f;
  endtask

  task automatic clear_env();
    inf_addr.delete(); inf_stale.delete();
    exp_pc_q.delete(); exp_q.delete(); mem_q.delete();
    pc_reg = 32'h0;
  endtask

  task automatic drive_idle();
    bus.pc = 32'h0; bus.flush = 1'b0; bus.imem_gnt = 1'b0;
    bus.imem_rvalid = 1'b0; bus.imem_rdata = 32'h0; bus.id_ready = 1'b0;
  endtask

  task automatic run_cycle();
    logic        fl, rv, exp_req, exp_grant, exp_stall, exp_valid, exp_pop, dut_grant;
    logic [31:0] target, resp;
    @(negedge clk);
    fl     = ($urandom_range(99) < p_fl);
    target = ($urandom_range(1) == 0) ? 32'h100 : ($urandom & 32'hFFFF_FFFC);
    rv     = (mem_q.size() > 0) && ($urandom_range(99) < p_rv);
    bus.pc          = pc_reg | 32'($urandom_range(3));
    bus.flush       = fl;
    bus.imem_gnt    = ($urandom_range(99) < p_gnt);
    bus.imem_rvalid = rv;
    bus.imem_rdata  = rv ? mem_word(mem_q[0]) : $urandom;
    bus.id_ready    = ($urandom_range(99) < p_rdy);
    #1;
    exp_req   = ((inf_addr.size() + exp_q.size()) < DEPTH) && !fl;
    exp_grant = exp_req && bus.imem_gnt;
    exp_stall = !fl && !exp_grant;
    exp_valid = (exp_q.size() != 0) && !fl;
    exp_pop   = exp_valid && bus.id_ready;
    check_eq("imem_req", 32'(bus.imem_req), 32'(exp_req));
    check_eq("stall_out", 32'(bus.stall_out), 32'(exp_stall));
    check_eq("instr_valid", 32'(bus.instr_valid), 32'(exp_valid));
    if (exp_req) check_eq("imem_addr", bus.imem_addr, pc_reg);
    if (exp_valid) begin
      check_eq("instr", bus.instr, exp_q[0]);
      check_eq("instr_pc", bus.instr_pc, exp_pc_q[0]);
    end
    dut_grant = bus.imem_req & bus.imem_gnt;
    @(posedge clk);
    if (rv) void'(mem_q.pop_front());
    if (dut_grant) mem_q.push_back(bus.imem_addr);
    if (fl) begin
      if (rv && inf_addr.size() > 0) begin
        void'(inf_addr.pop_front());
        void'(inf_stale.pop_front());
      end
      foreach (inf_stale[i]) inf_stale[i] = 1'b1;
      exp_q.delete();
      exp_pc_q.delete();
      pc_reg = target;
    end else begin
      if (exp_pop) begin
        void'(exp_q.pop_front());
        void'(exp_pc_q.pop_front());
      end
      if (rv && inf_addr.size() > 0) begin
        resp = inf_addr.pop_front();
        if (!inf_stale.pop_front()) begin
          exp_pc_q.push_back(resp);
          exp_q.push_back(mem_word(resp));
        end
      end
      if (exp_grant) begin
        inf_addr.push_back(pc_reg);
        inf_stale.push_back(1'b0);
      end
      if (!exp_stall) pc_reg = pc_reg + 32'd4;
    end
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) run_cycle();
  endtask

  task automatic async_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_instr_valid", 32'(bus.instr_valid), 32'h0);
    check_eq("rst_imem_req", 32'(bus.imem_req), 32'h0);
    check_eq("rst_stall_out", 32'(bus.stall_out), 32'h0);
    @(posedge clk);
    @(negedge clk);
    drive_idle();
    clear_env();
    rst_n = 1'b1;
  endtask

  initial begin
    drive_idle();
    clear_env();
    set_knobs(100, 100, 100, 0);
    #12;
    check_eq("init_instr_valid", 32'(bus.instr_valid), 32'h0);
    check_eq("init_imem_req", 32'(bus.imem_req), 32'h0);
    check_eq("init_stall_out", 32'(bus.stall_out), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    set_knobs(100, 100, 100, 0);  run_cycles(40);   // streaming
    set_knobs(30, 100, 100, 0);   run_cycles(60);   // memory backpressure
    set_knobs(100, 60, 0, 0);     run_cycles(20);   // queue fills up
    set_knobs(100, 60, 50, 0);    run_cycles(40);
    set_knobs(80, 70, 70, 8);     run_cycles(300);  // flushes mixed in
    set_knobs(100, 50, 30, 0);    run_cycles(6);
    async_reset();
    set_knobs(70, 60, 70, 10);    run_cycles(300);
    set_knobs(90, 30, 90, 5);     run_cycles(200);
    set_knobs(100, 100, 0, 0);    run_cycles(8);
    async_reset();
    set_knobs(100, 100, 100, 25); run_cycles(200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
